rect_plotter: RTL

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/plot_pkg.sv | 36 +++
 rtl/rect_plotter_if.sv | 31 +++
 rtl/rect_scan.sv | 53 +++++
 rtl/rect_plotter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared definitions for the rectangle plotter: screen geometry, erase colour,
// state encoding, the latched command record and a visibility helper.
package plot_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int SCREEN_MAX_X = SCREEN_W - 1;
  localparam int SCREEN_MAX_Y = SCREEN_H - 1;

  localparam logic [2:0] BG_COLOUR_DEFAULT = 3'b000;

  // Controller state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ERASE  = 2'd1;
  localparam state_t ST_DRAW   = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Everything captured from the bus when a command is accepted.
  typedef struct packed {
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [7:0] old_x;
    logic [6:0] old_y;
    logic [7:0] size_x;
    logic [6:0] size_y;
    logic [2:0] colour;
  } cmd_t;

  // A pixel is written only when it lies inside the visible window.
  function automatic logic visible(input logic [8:0] x, input logic [7:0] y,
                                   input logic [8:0] max_x, input logic [7:0] max_y);
    return (x <= max_x) && (y <= max_y);
  endfunction

endpackage

// File: rtl/rect_plotter_if.sv
// Command / pixel bus of the rectangle plotter. The master issues plot
// commands and receives the VGA pixel stream and status.
interface rect_plotter_if;

  logic       startPlot;
  logic [7:0] newX;
  logic [6:0] newY;
  logic [7:0] oldX;
  logic [6:0] oldY;
  logic [7:0] sizeX;
  logic [6:0] sizeY;
  logic [2:0] objColour;

  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       vgaPlot;
  logic       busy;
  logic       done;

  modport master (
    output startPlot, newX, newY, oldX, oldY, sizeX, sizeY, objColour,
    input  vgaX, vgaY, vgaColour, vgaPlot, busy, done
  );

  modport slave (
    input  startPlot, newX, newY, oldX, oldY, sizeX, sizeY, objColour,
    output vgaX, vgaY, vgaColour, vgaPlot, busy, done
  );

endinterface

// File: rtl/rect_scan.sv
// Row-major offset scanner over a size_x by size_y rectangle. Exposes the
// next offsets so the parent can register pixel outputs in the same cycle,
// and flags the final offset of the rectangle.
module rect_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_i,
  input  logic [7:0] size_x_i,
  input  logic [6:0] size_y_i,
  output logic [7:0] x_nxt_o,
  output logic [6:0] y_nxt_o,
  output logic       last_o
);

  logic [7:0] x_off_q, x_off_d;
  logic [6:0] y_off_q, y_off_d;
  logic       x_eol;

  assign x_eol  = (x_off_q == size_x_i - 8'd1);
  assign last_o = x_eol && (y_off_q == size_y_i - 7'd1);

  // Advance x, wrapping into the next row; any cycle without a step rewinds to 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    x_off_d = 8'd0;
    y_off_d = 7'd0;
    if (step_i) begin
      if (x_eol) begin
        x_off_d = 8'd0;
        y_off_d = y_off_q + 7'd1;
      end else begin
        x_off_d = x_off_q + 8'd1;
        y_off_d = y_off_q;
      end
    end
  end

  // Offset registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      x_off_q <= 8'd0;
      y_off_q <= 7'd0;
    end else begin
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
    end
  end

  assign x_nxt_o = x_off_d;
  assign y_nxt_o = y_off_d;

endmodule

// File: rtl/rect_plotter.sv
// Rectangle plotter: erases the previous rectangle in the background colour,
// then draws the new one, one pixel per cycle, with off-screen pixels clipped.
module rect_plotter
  import plot_pkg::*;
#(
  parameter int         maxX     = SCREEN_MAX_X,
  parameter int         maxY     = SCREEN_MAX_Y,
  parameter logic [2:0] bgColour = BG_COLOUR_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  rect_plotter_if.slave bus
);

  localparam logic [8:0] MAX_X9 = 9'(maxX);
  localparam logic [7:0] MAX_Y8 = 8'(maxY);

  state_t state_q, state_d;
  logic   first_q, first_d;
  cmd_t   cmd_q, cmd_d;

  logic       scan_step;
  logic       scan_last;
  logic [7:0] x_nxt;
  logic [6:0] y_nxt;

  logic       scanning_d;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] px;
  logic [7:0] py;

  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  rect_scan u_scan (
    .clk      (clk),
    .reset    (reset),
    .step_i   (scan_step),
    .size_x_i (cmd_q.size_x),
    .size_y_i (cmd_q.size_y),
    .x_nxt_o  (x_nxt),
    .y_nxt_o  (y_nxt),
    .last_o   (scan_last)
  );

  // Command sequencing: capture in IDLE, erase (unless first or empty), draw, finish.
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    cmd_d     = cmd_q;
    scan_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.startPlot) begin
          cmd_d.new_x  = bus.newX;
          cmd_d.new_y  = bus.newY;
          cmd_d.old_x  = bus.oldX;
          cmd_d.old_y  = bus.oldY;
          cmd_d.size_x = bus.sizeX;
          cmd_d.size_y = bus.sizeY;
          cmd_d.colour = bus.objColour;
          first_d      = 1'b0;
          if ((bus.sizeX == 8'd0) || (bus.sizeY == 7'd0)) begin
            state_d = ST_FINISH;
          end else if (first_q) begin
            state_d = ST_DRAW;
          end else begin
            state_d = ST_ERASE;
          end
        end
      end
      ST_ERASE: begin
        if (scan_last) state_d = ST_DRAW;
        else           scan_step = 1'b1;
      end
      ST_DRAW: begin
        if (scan_last) state_d = ST_FINISH;
        else           scan_step = 1'b1;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pixel and status outputs for the state being entered, so they can be registered.
  always_comb begin
    scanning_d = (state_d == ST_ERASE) || (state_d == ST_DRAW);
    base_x     = (state_d == ST_ERASE) ? cmd_d.old_x : cmd_d.new_x;
    base_y     = (state_d == ST_ERASE) ? cmd_d.old_y : cmd_d.new_y;
    px         = {1'b0, base_x} + {1'b0, x_nxt};
    py         = {1'b0, base_y} + {1'b0, y_nxt};

    vga_x_d      = scanning_d ? px[7:0] : 8'd0;
    vga_y_d      = scanning_d ? py[6:0] : 7'd0;
    vga_colour_d = 3'b000;
    if (state_d == ST_ERASE)     vga_colour_d = bgColour;
    else if (state_d == ST_DRAW) vga_colour_d = cmd_d.colour;
    vga_plot_d = scanning_d && visible(px, py, MAX_X9, MAX_Y8);
    busy_d     = scanning_d;
    done_d     = (state_d == ST_FINISH);
  end

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the command record is a handful of flops, not a memory, so it is reset with the rest.
      state_q      <= ST_IDLE;
      first_q      <= 1'b1;
      cmd_q        <= '0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'b000;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      cmd_q        <= cmd_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.vgaX      = vga_x_q;
  assign bus.vgaY      = vga_y_q;
  assign bus.vgaColour = vga_colour_q;
  assign bus.vgaPlot   = vga_plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
